// File: rtl/spi_master_tx_if.sv
// spi_master_tx_if -- bundle of the local handshake and SPI pins of spi_master_tx.
//
// Signals:
//   start    request a frame (local logic -> master)
//   tx_data  frame to send (local logic -> master)
//   rx_data  last received frame (master -> local logic)
//   busy     frame in progress, including the inter-frame gap
//   done     one-cycle pulse at frame end
//   sck      SPI clock, idles low
//   mosi     master data out
//   miso     slave data in
//   cs_n     active-low frame select
//
// Modports:
//   master  the spi_master_tx side
//   slave   the side that drives start/tx_data/miso and observes the rest
interface spi_master_tx_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] rx_data;
  logic              busy;
  logic              done;
  logic              sck;
  logic              mosi;
  logic              miso;
  logic              cs_n;

  modport master (
    input  start, tx_data, miso,
    output rx_data, busy, done, sck, mosi, cs_n
  );

  modport slave (
    output start, tx_data, miso,
    input  rx_data, busy, done, sck, mosi, cs_n
  );
endinterface

// File: rtl/spi_master_tx.sv
// spi_master_tx -- SPI mode-0 master, MSB first, one DATA_W-bit frame per start.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    spi_master_tx_if.master: start/tx_data/busy/done/rx_data handshake
//          toward local logic plus sck/mosi/miso/cs_n toward the slave
//
// Frame timeline (edge 0 = accepting edge, D = CLK_DIV):
//   cs_n falls and mosi carries the MSB at edge 0, sck rises at D, then
//   DATA_W pulses of D high / D low, a final D-long low phase, a D-long
//   hold, and done at edge (2*DATA_W+2)*D. busy drops GAP_CYCLES later.
// All outputs come straight from registers.
module spi_master_tx #(
  parameter int CLK_DIV    = 2,
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 2
) (
  input logic            clk,
  input logic            reset,
  spi_master_tx_if.master bus
);

  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W    = $clog2(DATA_W + 1);
  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_FULL   = BIT_W'(DATA_W);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST_V = GAP_W'(GAP_LAST);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic phase_end;
  logic gap_end;

  // Last clk cycle of the current sck half-period (or SETUP/HOLD wait).
  assign phase_end = (div_cnt_q == DIV_LAST);
  assign gap_end   = (gap_cnt_q == GAP_LAST_V);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_cnt_d = '0;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = '0;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          tx_sh_d   = bus.tx_data;
          mosi_d    = bus.tx_data[DATA_W-1];
          rx_sh_d   = '0;
          bit_cnt_d = '0;
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
          state_d   = SETUP;
        end
      end

      SETUP: begin
        if (phase_end) begin
          sck_d   = 1'b1;
          state_d = SHIFT;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      SHIFT: begin
        if (!phase_end) begin
          div_cnt_d = div_cnt_q + 1'b1;
        end else if (sck_q) begin
          // Falling edge: sample miso before the slave reacts to this edge,
          // then present the next bit for the following rising edge.
          sck_d     = 1'b0;
          rx_sh_d   = {rx_sh_q[DATA_W-2:0], bus.miso};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q < BIT_LAST) begin
            tx_sh_d = tx_sh_q << 1;
            mosi_d  = tx_sh_q[DATA_W-2];
          end
        end else if (bit_cnt_q < BIT_FULL) begin
          sck_d = 1'b1;
        end else begin
          // Final low phase has run its full length; sck stays low.
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (!phase_end) begin
          div_cnt_d = div_cnt_q + 1'b1;
        end else begin
          cs_n_d    = 1'b1;
          rx_data_d = rx_sh_q;
          done_d    = 1'b1;
          mosi_d    = 1'b0;
          if (GAP_CYCLES == 0) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = GAP;
          end
        end
      end

      GAP: begin
        if (gap_end) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.sck     = sck_q;
  assign bus.mosi    = mosi_q;
  assign bus.cs_n    = cs_n_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// tb_spi_master_tx -- self-checking bench for spi_master_tx.
//
// dut_a: CLK_DIV=2, GAP_CYCLES=2, miso from loopback or a behavioural slave.
// dut_b: CLK_DIV=1, GAP_CYCLES=0, miso looped back, used for back-to-back.
// Expected timing comes from the frame formula: done (2*8+2)*CLK_DIV edges
// after accept, busy low GAP_CYCLES edges after done.
module tb_spi_master_tx;

  localparam int CDA   = 2;
  localparam int GAPA  = 2;
  localparam int CDB   = 1;
  localparam int NBITS = 8;
  localparam int DONE_A = (2 * NBITS + 2) * CDA;
  localparam int DONE_B = (2 * NBITS + 2) * CDB;

  logic clk = 1'b0;
  logic reset_a = 1'b1;
  logic reset_b = 1'b1;
  logic lb_mode = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  spi_master_tx_if #(.DATA_W(NBITS)) ifa ();
  spi_master_tx_if #(.DATA_W(NBITS)) ifb ();

  spi_master_tx #(.CLK_DIV(CDA), .DATA_W(NBITS), .GAP_CYCLES(GAPA)) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (ifa)
  );

  spi_master_tx #(.CLK_DIV(CDB), .DATA_W(NBITS), .GAP_CYCLES(0)) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (ifb)
  );

  always #5 clk = ~clk;

  // Behavioural mode-0 slave: bit 7 valid while cs_n is high / before the
  // first rise, next bit after each sck fall, mosi captured on sck rise.
  logic [7:0] sl_tx  = 8'h00;
  logic [7:0] sl_rx  = 8'h00;
  logic [3:0] sl_idx = 4'd0;
  logic       sl_miso;

  always @(negedge ifa.sck or posedge ifa.cs_n) begin
    if (ifa.cs_n) sl_idx <= 4'd0;
    else          sl_idx <= sl_idx + 4'd1;
  end

  always @(posedge ifa.sck) sl_rx <= {sl_rx[6:0], ifa.mosi};

  assign sl_miso  = sl_idx[3] ? 1'b0 : sl_tx[3'd7 - sl_idx[2:0]];
  assign ifa.miso = lb_mode ? ifa.mosi : sl_miso;
  assign ifb.miso = ifb.mosi;

  // Runs one dut_a frame and records what was observed; scenario tasks judge.
  // Stimulus for edge k is applied at the negedge before it.
  task automatic drive_frame_a(input logic [7:0] tx, input int p1, input int p2,
                               input int chg, input logic [7:0] chg_val,
                               output int done_k, output int rises, output int falls,
                               output int cs_low, output int busy_fall, output int done_w,
                               output logic [7:0] rx_at_done, output logic [7:0] mosi_seen);
    logic prev_sck;
    done_k = -1; rises = 0; falls = 0; cs_low = 0; busy_fall = -1; done_w = 0;
    rx_at_done = 8'h00; mosi_seen = 8'h00;
    @(negedge clk);
    ifa.start = 1'b1;
    ifa.tx_data = tx;
    @(posedge clk);
    @(negedge clk);
    ifa.start = 1'b0;
    prev_sck = ifa.sck;
    if (!ifa.cs_n) cs_low++;
    for (int k = 1; k <= 200 && busy_fall < 0; k++) begin
      ifa.start = (k == p1) || (k == p2);
      if (k == chg) ifa.tx_data = chg_val;
      @(posedge clk);
      @(negedge clk);
      if (ifa.sck && !prev_sck) begin
        rises++;
        mosi_seen = {mosi_seen[6:0], ifa.mosi};
      end
      if (!ifa.sck && prev_sck) falls++;
      prev_sck = ifa.sck;
      if (!ifa.cs_n) cs_low++;
      if (ifa.done) begin
        if (done_k < 0) begin
          done_k = k;
          rx_at_done = ifa.rx_data;
        end
        done_w++;
      end
      if (done_k >= 0 && !ifa.busy && busy_fall < 0) busy_fall = k;
    end
    ifa.start = 1'b0;
  endtask

  task automatic test_reset;
    ifa.start = 1'b0; ifa.tx_data = 8'h00;
    ifb.start = 1'b0; ifb.tx_data = 8'h00;
    reset_a = 1'b1; reset_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({ifa.sck, ifa.cs_n, ifa.mosi, ifa.busy, ifa.done} !== 5'b01000) begin
      n_err++;
      $display("FAIL reset_a_pins: got %b, want 01000 (sck cs_n mosi busy done)",
               {ifa.sck, ifa.cs_n, ifa.mosi, ifa.busy, ifa.done});
    end
    n_vec++;
    if (ifa.rx_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_a_rx: got %02h, want 00", ifa.rx_data);
    end
    n_vec++;
    if ({ifb.sck, ifb.cs_n, ifb.mosi, ifb.busy, ifb.done, ifb.rx_data} !== {5'b01000, 8'h00}) begin
      n_err++;
      $display("FAIL reset_b: got %b, want 0100000000000",
               {ifb.sck, ifb.cs_n, ifb.mosi, ifb.busy, ifb.done, ifb.rx_data});
    end
    reset_a = 1'b0; reset_b = 1'b0;
    $display("reset: outputs checked on both instances");
  endtask

  task automatic test_idle;
    int bad;
    bad = 0;
    ifa.start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ifa.sck || !ifa.cs_n || ifa.done || ifa.busy) bad++;
    end
    n_vec++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL idle_quiet: got %0d active cycles, want 0", bad);
    end
    $display("idle: 100 cycles, active cycles=%0d", bad);
  endtask

  task automatic test_loopback(input logic [7:0] tx);
    int done_k, rises, falls, cs_low, busy_fall, done_w, unstable;
    logic [7:0] rx, ms;
    lb_mode = 1'b1;
    drive_frame_a(tx, 0, 0, 0, 8'h00, done_k, rises, falls, cs_low, busy_fall, done_w, rx, ms);
    n_vec++;
    if (done_k !== DONE_A) begin
      n_err++; $display("FAIL lb_done_time: got %0d, want %0d", done_k, DONE_A);
    end
    n_vec++;
    if (rises !== NBITS || falls !== NBITS) begin
      n_err++; $display("FAIL lb_sck_edges: got rise=%0d fall=%0d, want %0d each", rises, falls, NBITS);
    end
    n_vec++;
    if (cs_low !== DONE_A) begin
      n_err++; $display("FAIL lb_cs_low: got %0d cycles, want %0d", cs_low, DONE_A);
    end
    n_vec++;
    if (done_w !== 1) begin
      n_err++; $display("FAIL lb_done_width: got %0d, want 1", done_w);
    end
    n_vec++;
    if (rx !== tx) begin
      n_err++; $display("FAIL lb_rx: got %02h, want %02h", rx, tx);
    end
    n_vec++;
    if (ms !== tx) begin
      n_err++; $display("FAIL lb_mosi_order: got %02h, want %02h", ms, tx);
    end
    n_vec++;
    if (busy_fall - done_k !== GAPA) begin
      n_err++; $display("FAIL lb_gap: got %0d, want %0d", busy_fall - done_k, GAPA);
    end
    unstable = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ifa.rx_data !== tx || !ifa.cs_n) unstable++;
    end
    n_vec++;
    if (unstable !== 0) begin
      n_err++; $display("FAIL lb_rx_hold: got %0d unstable cycles, want 0", unstable);
    end
    $display("loopback: tx=%02h rx=%02h done@%0d gap=%0d", tx, rx, done_k, busy_fall - done_k);
  endtask

  task automatic test_slave(input logic [7:0] tx, input logic [7:0] stx);
    int done_k, rises, falls, cs_low, busy_fall, done_w;
    logic [7:0] rx, ms;
    lb_mode = 1'b0;
    sl_tx = stx;
    drive_frame_a(tx, 0, 0, 0, 8'h00, done_k, rises, falls, cs_low, busy_fall, done_w, rx, ms);
    n_vec++;
    if (rx !== stx) begin
      n_err++; $display("FAIL slave_rx: got %02h, want %02h", rx, stx);
    end
    n_vec++;
    if (sl_rx !== tx) begin
      n_err++; $display("FAIL slave_capture: got %02h, want %02h", sl_rx, tx);
    end
    n_vec++;
    if (ms !== tx) begin
      n_err++; $display("FAIL slave_mosi_order: got %02h, want %02h", ms, tx);
    end
    n_vec++;
    if (done_k !== DONE_A) begin
      n_err++; $display("FAIL slave_done_time: got %0d, want %0d", done_k, DONE_A);
    end
    lb_mode = 1'b1;
    $display("slave: tx=%02h slave_got=%02h slave_sent=%02h rx=%02h", tx, sl_rx, stx, rx);
  endtask

  task automatic test_ignore;
    int done_k, rises, falls, cs_low, busy_fall, done_w, extra;
    logic [7:0] rx, ms;
    lb_mode = 1'b1;
    drive_frame_a(8'hA5, 5, 20, 3, 8'h3C, done_k, rises, falls, cs_low, busy_fall, done_w, rx, ms);
    n_vec++;
    if (rx !== 8'hA5 || ms !== 8'hA5) begin
      n_err++; $display("FAIL ignore_data: got rx=%02h mosi=%02h, want A5/A5", rx, ms);
    end
    n_vec++;
    if (done_k !== DONE_A || done_w !== 1) begin
      n_err++; $display("FAIL ignore_done: got done@%0d width %0d, want %0d width 1", done_k, done_w, DONE_A);
    end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!ifa.cs_n || ifa.busy || ifa.done) extra++;
    end
    n_vec++;
    if (extra !== 0) begin
      n_err++; $display("FAIL ignore_single_frame: got %0d active cycles after frame, want 0", extra);
    end
    ifa.tx_data = 8'h00;
    $display("ignore: rx=%02h done@%0d extra_activity=%0d", rx, done_k, extra);
  endtask

  task automatic test_reset_abort;
    int done_k, rises, falls, cs_low, busy_fall, done_w, seen;
    logic [7:0] rx, ms;
    lb_mode = 1'b1;
    @(negedge clk);
    ifa.start = 1'b1; ifa.tx_data = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    ifa.start = 1'b0;
    repeat (15) @(posedge clk);
    #3 reset_a = 1'b1;
    #1;
    n_vec++;
    if ({ifa.sck, ifa.cs_n, ifa.mosi, ifa.busy, ifa.done} !== 5'b01000) begin
      n_err++; $display("FAIL abort_pins: got %b, want 01000", {ifa.sck, ifa.cs_n, ifa.mosi, ifa.busy, ifa.done});
    end
    n_vec++;
    if (ifa.rx_data !== 8'h00) begin
      n_err++; $display("FAIL abort_rx: got %02h, want 00", ifa.rx_data);
    end
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (ifa.done || !ifa.cs_n) seen++;
    end
    reset_a = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ifa.done || !ifa.cs_n || ifa.sck) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      n_err++; $display("FAIL abort_no_done: got %0d active cycles, want 0", seen);
    end
    drive_frame_a(8'h81, 0, 0, 0, 8'h00, done_k, rises, falls, cs_low, busy_fall, done_w, rx, ms);
    n_vec++;
    if (rx !== 8'h81 || done_k !== DONE_A) begin
      n_err++; $display("FAIL abort_next_frame: got rx=%02h done@%0d, want 81 @%0d", rx, done_k, DONE_A);
    end
    $display("reset_abort: post-abort activity=%0d next rx=%02h done@%0d", seen, rx, done_k);
  endtask

  task automatic test_back_to_back(input logic [7:0] t0, input logic [7:0] t1);
    int dk[$];
    logic [7:0] rxs[$];
    int cs_high, d0, d1;
    logic [7:0] r0, r1;
    cs_high = 0;
    @(negedge clk);
    ifb.start = 1'b1; ifb.tx_data = t0;
    @(posedge clk);
    @(negedge clk);
    ifb.tx_data = t1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (ifb.done) begin
        dk.push_back(k);
        rxs.push_back(ifb.rx_data);
      end
      if (ifb.cs_n && dk.size() < 2) cs_high++;
      if (k == DONE_B + 1) begin
        ifb.start = 1'b0;
        ifb.tx_data = ~t1;
      end
    end
    d0 = (dk.size() > 0) ? dk[0] : -1;
    d1 = (dk.size() > 1) ? dk[1] : -1;
    r0 = (rxs.size() > 0) ? rxs[0] : 8'hxx;
    r1 = (rxs.size() > 1) ? rxs[1] : 8'hxx;
    n_vec++;
    if (dk.size() !== 2) begin
      n_err++; $display("FAIL b2b_frames: got %0d done pulses, want 2", dk.size());
    end
    n_vec++;
    if (d0 !== DONE_B || d1 - d0 !== DONE_B + 1) begin
      n_err++; $display("FAIL b2b_timing: got done@%0d,%0d, want %0d,%0d", d0, d1, DONE_B, 2 * DONE_B + 1);
    end
    n_vec++;
    if (r0 !== t0 || r1 !== t1) begin
      n_err++; $display("FAIL b2b_rx: got %02h,%02h, want %02h,%02h", r0, r1, t0, t1);
    end
    n_vec++;
    if (cs_high !== 1) begin
      n_err++; $display("FAIL b2b_cs_gap: got %0d high cycles, want 1", cs_high);
    end
    $display("back_to_back: tx=%02h,%02h rx=%02h,%02h done@%0d,%0d cs_gap=%0d",
             t0, t1, r0, r1, d0, d1, cs_high);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_idle;
    test_loopback(8'hA5);
    repeat (3) test_loopback(8'($urandom));
    test_slave(8'h5A, 8'h3C);
    repeat (2) test_slave(8'($urandom), 8'($urandom));
    test_ignore;
    test_reset_abort;
    test_back_to_back(8'h01, 8'h80);
    test_back_to_back(8'($urandom), 8'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
- SPI mode-0 master, MSB first, 8-bit frames (DATA_W).
- Lets the FPGA drive the system's state/result byte link as the initiating end, for bench and board use against the existing negedge-update / posedge-shift slave.
- Generates sck, frames the transfer with cs_n, shifts tx_data out on mosi and captures miso into rx_data.
- start/busy/done handshake toward local logic.

Parameters:
- CLK_DIV, 2, clk cycles per sck half-period (legal ≥1); sck period = 2·CLK_DIV clk cycles.
- DATA_W, 8, bits per frame.
- GAP_CYCLES, 2, clk cycles busy stays high after done, with cs_n high (inter-frame gap); 0 allowed.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a frame; sampled only while busy=0
- tx_data  input  DATA_W  frame to send; latched on the accepting edge
- rx_data  output  DATA_W  last received frame; updated with done
- busy  output  1  high from accept until gap ends
- done  output  1  one-cycle pulse at frame end
- sck  output  1  SPI clock, idles low
- mosi  output  1  master data out
- miso  input  1  slave data in
- cs_n  output  1  active-low frame select

Behaviour:
- Reset (async assert, sync release): state IDLE, sck=0, cs_n=1, mosi=0, busy=0, done=0, rx_data=0, internal counters 0.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE:
  - sck=0, cs_n=1, busy=0.
  - On a clk edge with start=1: latch tx_data into tx shift register; cs_n←0; mosi←tx_data[DATA_W-1]; busy←1; go to SETUP.
- SETUP:
  - Hold for CLK_DIV cycles, then sck←1 and go to SHIFT.
- SHIFT (DATA_W sck pulses, high then low, each phase CLK_DIV cycles):
  - On the edge that drives sck 1→0: capture miso into the LSB of the rx shift register (shift left).
  - On that same edge, mosi←next tx bit if bits remain.
  - On the edge that ends a low phase, drive sck 0→1 if bits remain.
  - After the DATA_W-th falling edge, go to HOLD with sck=0.
  - Exactly DATA_W rising and DATA_W falling sck edges occur per frame.
- HOLD:
  - Hold for CLK_DIV cycles, then on one edge: cs_n←1, rx_data←rx shift register, done←1 for that single cycle, mosi←0.
  - Go to GAP, or go directly to IDLE with busy←0 when GAP_CYCLES=0.
- GAP:
  - Count GAP_CYCLES cycles with cs_n=1 and busy=1, then busy←0 and go to IDLE.
- Latency:
  - done rises 18·CLK_DIV clk edges after the accepting edge (DATA_W=8); 36 edges at the default CLK_DIV.
  - busy falls GAP_CYCLES edges after the done edge.
- start while busy=1 is ignored. No queuing, no error flag.
- With GAP_CYCLES=0, start during the done cycle is accepted on the next edge (back-to-back). cs_n is high for exactly 1 cycle between frames.
- tx_data changes after accept have no effect on the current frame.
- rx_data is stable between done pulses.
- miso is sampled unsynchronised; the board constraint is miso stable CLK_DIV cycles after sck falls. The slave updates on negedge sck, and master capture precedes the master's own falling edge.
- Reset asserted mid-frame aborts immediately to reset values: cs_n=1, sck=0, rx_data=0. No done pulse. A partial frame is never reported.
- With CLK_DIV=1, sck toggles every clk cycle. All counts above hold with CLK_DIV=1.
- Counters are sized $clog2 of their maximum+1. The bit counter does not wrap within a frame.

Test Plan:
- Loopback (mosi tied to miso), CLK_DIV=2, start with tx_data=0xA5 → exactly 8 sck rising edges; cs_n low 36 cycles; done pulse 1 cycle at edge 36; rx_data=0xA5; busy low 2 cycles after done.
- Behavioural mode-0 slave returning 0x3C (drives bit7 before the first sck rise, updates on sck negedge), tx 0x5A → slave captures 0x5A; rx_data=0x3C; mosi bit order MSB first checked at each sck rise.
- start pulsed again at cycles 5 and 20 of a frame, and tx_data changed at cycle 3 → ignored; single frame; rx and tx reflect the original 0xA5 only.
- Reset asserted at cycle 15 of a frame (loopback 0xFF) → sck=0, cs_n=1, busy=0, rx_data=0x00 asynchronously; no done; next frame 0x81 completes correctly.
- CLK_DIV=1, GAP_CYCLES=0, start held high continuously with loopback and tx 0x01 then 0x80 → back-to-back frames; done every 19 cycles (18 plus 1 cs_n-high cycle); rx_data 0x01 then 0x80.
- Idle check after reset with start=0 for 100 cycles → sck never toggles; cs_n=1; done never pulses.
